// File: rtl/arith_sequencer.sv
// Multi-cycle unsigned ADD/SUB/MUL/DIV sequencer.
// All arithmetic goes through one shared carry-lookahead adder.
module arith_sequencer_cla #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int L = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]      w_y;
  logic [L:0][N-1:0] w_g;
  logic [L:0][N-1:0] w_p;
  logic [N:0]        w_c;

  // cin=1 turns the adder into x - y (invert plus one)
  assign w_y    = cin ? ~y : y;
  assign w_g[0] = x & w_y;
  assign w_p[0] = x ^ w_y;

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_mrg
        assign w_g[lv+1][i] = w_g[lv][i]
                            | (w_p[lv][i] & w_g[lv][i-D]);
        assign w_p[lv+1][i] = w_p[lv][i] & w_p[lv][i-D];
      end else begin : g_cpy
        assign w_g[lv+1][i] = w_g[lv][i];
        assign w_p[lv+1][i] = w_p[lv][i];
      end
    end
  end

  assign w_c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_car
    assign w_c[i+1] = w_g[L][i] | (w_p[L][i] & cin);
  end

  assign sum  = w_p[0] ^ w_c[N-1:0];
  assign cout = w_c[N];

endmodule

module arith_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] remainder,
  output logic         ovr,
  output logic         dbz
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDSUB = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [2:0]     r_state;
  logic [1:0]     r_op;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_result;
  logic [N-1:0]   r_rem;
  logic           r_ovr;
  logic           r_dbz;

  logic           w_st_mul;
  logic           w_st_div;
  logic           w_accept;
  logic           w_last;
  logic [N-1:0]   w_add_x;
  logic [N-1:0]   w_add_y;
  logic           w_cin;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_take;
  logic [2*N-1:0] w_mul_next;
  logic [2*N-1:0] w_div_next;

  assign w_st_mul = (r_state == S_MUL);
  assign w_st_div = (r_state == S_DIV);
  assign w_accept = start
                  & ((r_state == S_IDLE) | (r_state == S_FIN));
  assign w_last   = (r_cnt == CW'(N - 1));

  always_comb begin
    w_add_x = r_a;
    w_add_y = r_b;
    w_cin   = r_op[0];
    unique case (1'b1)
      w_st_mul: begin
        w_add_x = r_acc[2*N-1:N];
        w_add_y = r_a;
        w_cin   = 1'b0;
      end
      w_st_div: begin
        w_add_x = r_acc[2*N-2:N-1];
        w_add_y = r_b;
        w_cin   = 1'b1;
      end
      default: ;
    endcase
  end

  arith_sequencer_cla #(.N(N)) u_cla (
    .x    (w_add_x),
    .y    (w_add_y),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // multiplier sits in acc low half and shifts out as product bits enter
  assign w_mul_next = r_acc[0]
    ? {w_cout, w_sum, r_acc[N-1:1]}
    : {1'b0, r_acc[2*N-1:N], r_acc[N-1:1]};

  // dropped MSB means the shifted remainder is >= 2^N > divisor
  assign w_take     = r_acc[2*N-1] | w_cout;
  assign w_div_next = {
    w_take ? w_sum : r_acc[2*N-2:N-1],
    r_acc[N-2:0],
    w_take
  };

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_ovr    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            if (op == 2'b10) begin
              r_acc <= {{N{1'b0}}, b};
            end else begin
              r_acc <= {{N{1'b0}}, a};
            end
            if (!op[1]) begin
              r_state <= S_ADDSUB;
            end else if (!op[0]) begin
              r_state <= S_MUL;
            end else begin
              r_state <= S_DIV;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADDSUB: begin
          r_result <= w_sum;
          r_rem    <= '0;
          r_ovr    <= r_op[0] ^ w_cout;
          r_dbz    <= 1'b0;
          r_state  <= S_FIN;
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_mul_next[N-1:0];
            r_rem    <= '0;
            r_ovr    <= |w_mul_next[2*N-1:N];
            r_dbz    <= 1'b0;
            r_state  <= S_FIN;
          end
        end
        S_DIV: begin
          if (r_b == '0) begin
            r_result <= '1;
            r_rem    <= r_a;
            r_ovr    <= 1'b0;
            r_dbz    <= 1'b1;
            r_state  <= S_FIN;
          end else begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= w_div_next[N-1:0];
              r_rem    <= w_div_next[2*N-1:N];
              r_ovr    <= 1'b0;
              r_dbz    <= 1'b0;
              r_state  <= S_FIN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_ADDSUB) | w_st_mul | w_st_div;
  assign done      = (r_state == S_FIN);
  assign result    = r_result;
  assign remainder = r_rem;
  assign ovr       = r_ovr;
  assign dbz       = r_dbz;

endmodule

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits (N >= 4).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled only when busy=0.
REQ-005 SHALL have port op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV (all unsigned).
REQ-006 SHALL have port a  input  N  first operand (augend/minuend/multiplicand/dividend).
REQ-007 SHALL have port b  input  N  second operand (addend/subtrahend/multiplier/divisor).
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result/remainder/ovr/dbz valid.
REQ-010 SHALL have port result  output  N  sum, difference, low product or quotient.
REQ-011 SHALL have port remainder  output  N  DIV remainder; 0 for other ops.
REQ-012 SHALL have port ovr  output  1  ADD carry-out, SUB borrow (a<b), MUL product high half nonzero; 0 for DIV.
REQ-013 SHALL have port dbz  output  1  DIV with b=0; 0 otherwise.

Function
REQ-014 SHALL hold one N-bit carry-lookahead adder instance (cin=1 selects B inversion plus one), shared by all ops via input muxes; no other N-bit adder/subtractor permitted.
REQ-015 SHALL implement FSM states IDLE, ADDSUB, MUL, DIV, FIN.
REQ-016 IDLE: busy=0; start=1 at rising edge captures op, a, b into registers and moves to ADDSUB (op 0x), MUL (op 10) or DIV (op 11).
REQ-017 ADDSUB: one cycle; adder computes a+b (cin=0) or a-b (cin=1); result, ovr registered (SUB ovr = NOT carry-out); -> FIN.
REQ-018 MUL: shift-add over exactly N cycles on a 2N-bit accumulator; each cycle adds multiplicand to high half through the adder when current multiplier LSB=1, then shifts right including carry-out; after cycle N, result = product[N-1:0], ovr = |product[2N-1:N]; -> FIN.
REQ-019 DIV, b!=0: restoring division over exactly N cycles; each cycle shifts partial remainder left taking next dividend bit, trial-subtracts divisor via adder (cin=1), keeps difference and sets quotient bit 1 when shifted-out MSB=1 or carry-out=1, else restores; after cycle N result=quotient, remainder=a mod b; -> FIN.
REQ-020 DIV, b=0: SHALL skip iteration; result = all ones, remainder = a, dbz=1, one cycle; -> FIN.
REQ-021 FIN: done=1, busy=0 for exactly one cycle; outputs valid; -> IDLE, or directly accepts a new start in this cycle (back-to-back, same capture as IDLE).
REQ-022 Latency from start edge to done high: ADD/SUB 2 cycles, MUL N+1, DIV N+1, DIV by zero 2.
REQ-023 busy SHALL be 1 in ADDSUB, MUL, DIV and 0 in IDLE, FIN; start, op, a, b while busy=1 SHALL be ignored.
REQ-024 result, remainder, ovr, dbz SHALL hold last completed values until the next done; they may change only on the edge entering FIN.
REQ-025 Input operands SHALL be read only at the capture edge; later input changes do not affect an operation in flight.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, remainder=0, ovr=0, dbz=0, clear all datapath registers, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse; first start after reset_n rises SHALL behave as from power-up.

Verification (N=8)
REQ-028 ADD a=0xF0 b=0x20 -> done at edge+2, result=0x10, ovr=1; ADD 0x12+0x34 -> 0x46, ovr=0.
REQ-029 SUB a=0x05 b=0x07 -> result=0xFE, ovr=1; SUB 0x07-0x05 -> 0x02, ovr=0.
REQ-030 MUL a=0x0F b=0x11 -> done at edge+9, result=0xFF, ovr=0; MUL 0x10*0x10 -> 0x00, ovr=1; busy high exactly 8 cycles.
REQ-031 DIV a=0xC8 b=0x07 -> done at edge+9, result=0x1C, remainder=0x04, dbz=0; DIV a=0x2A b=0x00 -> edge+2, result=0xFF, remainder=0x2A, dbz=1.
REQ-032 Start held high with changing operands during MUL -> ignored; start in FIN cycle -> accepted, second done follows with correct result.
REQ-033 reset_n pulsed low at DIV iteration 4 -> outputs 0 asynchronously, no done; subsequent ADD 0x01+0x01 -> 0x02.
